// File: rtl/game_timer_pkg.sv
// Shared types and helpers for the game countdown/up timer.
// BCD <-> seconds conversion and the stability-scaled period.
package game_timer_pkg;

  typedef enum logic [1:0] {
    RUN,
    ADJ,
    EXPIRED
  } state_t;

  localparam logic [15:0] BCD_MAX = 16'h9959;
  localparam int unsigned SEC_MAX = 5999;

  function automatic logic [12:0] bcd_to_sec(
    input logic [15:0] b
  );
    return 13'(b[15:12]) * 13'd600
         + 13'(b[11:8])  * 13'd60
         + 13'(b[7:4])   * 13'd10
         + 13'(b[3:0]);
  endfunction

  function automatic logic [15:0] sec_to_bcd(
    input logic [12:0] s
  );
    logic [12:0] m;
    logic [12:0] ss;
    m  = s / 13'd60;
    ss = s % 13'd60;
    return {4'(m / 13'd10), 4'(m % 13'd10),
            4'(ss / 13'd10), 4'(ss % 13'd10)};
  endfunction

  function automatic int unsigned period(
    input int unsigned base,
    input int unsigned levels,
    input int unsigned s
  );
    int unsigned se;
    se = (s > levels - 1) ? levels - 1 : s;
    return base - ((levels - 1 - se) * base)
                  / (2 * (levels - 1));
  endfunction

endpackage

// File: rtl/game_timer_ext_alu.sv
// Combinational MM:SS BCD adder/subtractor, clamped to 00:00..99:59.
// Out-of-range amounts contribute zero seconds.
module bcd_mmss_alu
  import game_timer_pkg::*;
(
  input  logic [15:0] cur,
  input  logic [7:0]  amt_bcd,
  input  logic        sub,
  output logic [15:0] res
);

  logic        amt_ok;
  logic [12:0] cur_s;
  logic [12:0] amt_s;
  logic [13:0] sum;

  always_comb begin
    amt_ok = (amt_bcd[7:4] <= 4'd5)
          && (amt_bcd[3:0] <= 4'd9);
    amt_s  = '0;
    if (amt_ok)
      amt_s = 13'(amt_bcd[7:4]) * 13'd10
            + 13'(amt_bcd[3:0]);
    cur_s = bcd_to_sec(cur);
    if (sub)
      sum = (cur_s >= amt_s)
          ? {1'b0, cur_s - amt_s} : '0;
    else
      sum = {1'b0, cur_s} + {1'b0, amt_s};
    if (sum > 14'(SEC_MAX))
      sum = 14'(SEC_MAX);
    res = sec_to_bcd(sum[12:0]);
  end

endmodule

// File: rtl/game_timer_ext.sv
// MM:SS game timer with load, up/down, speed levels and adjust port.
// TIMER_WARN_BLINK_EN: warn blinks on each tick instead of a level.
module game_timer_ext
  import game_timer_pkg::*;
#(
  parameter int unsigned CLK_FREQ  = 50_000_000,
  parameter int unsigned SIM_DIV   = 1,
  parameter int unsigned LEVELS    = 10,
  parameter int unsigned LVL_W     = 4,
  parameter logic [15:0] START_BCD = 16'h0500,
  parameter int unsigned WARN_SEC  = 30
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             load,
  input  logic [15:0]      load_bcd,
  input  logic             mode_up,
  input  logic [LVL_W-1:0] stability,
  input  logic             adj_valid,
  output logic             adj_ready,
  input  logic             adj_sub,
  input  logic [7:0]       adj_sec_bcd,
  output logic [15:0]      time_bcd,
  output logic             tick,
  output logic             warn,
  output logic             time_out
);

  localparam int unsigned BASE = CLK_FREQ / SIM_DIV;
  localparam int unsigned CW   = $clog2(BASE + 1);

  state_t           state;
  logic [CW-1:0]    presc;
  logic [CW-1:0]    per_tab [LEVELS];
  logic [CW-1:0]    per_m1;
  logic [LVL_W-1:0] s_eff;
  logic             pending;
  logic [7:0]       adj_q;
  logic             adj_sub_q;
  logic             terminal;
  logic             due;
  logic             accept;
  logic             step_now;
  logic [7:0]       alu_amt;
  logic             alu_sub;
  logic [15:0]      alu_res;
  logic             alu_term;
  logic             warn_cond;

  for (genvar i = 0; i < LEVELS; i++) begin : g_per
    assign per_tab[i] = CW'(period(BASE, LEVELS, i));
  end

  assign s_eff = (stability > LVL_W'(LEVELS - 1))
               ? LVL_W'(LEVELS - 1) : stability;
  assign per_m1 = per_tab[s_eff] - CW'(1);

  assign terminal = mode_up ? (time_bcd == BCD_MAX)
                            : (time_bcd == 16'h0000);
  assign due      = enable && (presc >= per_m1);
  assign accept   = adj_valid && !load && (state != ADJ);
  assign step_now = (state == RUN) && !terminal
                 && (pending || due) && !accept;

  // one ALU serves both the 1 s step and the adjustment
  assign alu_amt  = (state == ADJ) ? adj_q : 8'h01;
  assign alu_sub  = (state == ADJ) ? adj_sub_q : !mode_up;
  assign alu_term = mode_up ? (alu_res == BCD_MAX)
                            : (alu_res == 16'h0000);

  bcd_mmss_alu u_alu (
    .cur     (time_bcd),
    .amt_bcd (alu_amt),
    .sub     (alu_sub),
    .res     (alu_res)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= RUN;
      time_bcd  <= START_BCD;
      presc     <= '0;
      pending   <= 1'b0;
      tick      <= 1'b0;
      time_out  <= 1'b0;
      adj_ready <= 1'b1;
      adj_q     <= '0;
      adj_sub_q <= 1'b0;
    end else if (load) begin
      state     <= RUN;
      time_bcd  <= load_bcd;
      presc     <= '0;
      pending   <= 1'b0;
      tick      <= 1'b0;
      time_out  <= 1'b0;
      adj_ready <= 1'b1;
    end else begin
      tick <= step_now;
      unique case (state)
        RUN: begin
          if (accept) begin
            state     <= ADJ;
            adj_ready <= 1'b0;
            adj_q     <= adj_sec_bcd;
            adj_sub_q <= adj_sub;
            if (!terminal && (pending || due))
              pending <= 1'b1;
          end else if (terminal) begin
            state    <= EXPIRED;
            time_out <= 1'b1;
            pending  <= 1'b0;
          end else if (step_now) begin
            time_bcd <= alu_res;
            presc    <= '0;
            pending  <= 1'b0;
            if (alu_term) begin
              state    <= EXPIRED;
              time_out <= 1'b1;
            end
          end else if (enable) begin
            presc <= presc + CW'(1);
          end
        end
        ADJ: begin
          time_bcd  <= alu_res;
          adj_ready <= 1'b1;
          if (alu_term) begin
            state    <= EXPIRED;
            time_out <= 1'b1;
            pending  <= 1'b0;
          end else begin
            state    <= RUN;
            time_out <= 1'b0;
          end
        end
        EXPIRED: begin
          if (accept) begin
            state     <= ADJ;
            adj_ready <= 1'b0;
            adj_q     <= adj_sec_bcd;
            adj_sub_q <= adj_sub;
          end
        end
        default: state <= RUN;
      endcase
    end
  end

  assign warn_cond = !mode_up && !time_out
    && (bcd_to_sec(time_bcd) <= 13'(WARN_SEC));

`ifdef TIMER_WARN_BLINK_EN
  logic blink;

  always_ff @(posedge clk) begin
    if (rst || !warn_cond)
      blink <= 1'b1;
    else if (tick)
      blink <= ~blink;
  end

  assign warn = warn_cond && blink;
`else
  assign warn = warn_cond;
`endif

endmodule

// File: tb/tb_game_timer_ext.sv
// Bench for game_timer_ext: load vector table, directed corner
// sequences, and random traffic against a seconds-based model.
module tb_game_timer_ext;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        enable = 1'b0;
  logic        load = 1'b0;
  logic [15:0] load_bcd = '0;
  logic        mode_up = 1'b0;
  logic [3:0]  stability = 4'd9;
  logic        adj_valid = 1'b0;
  logic        adj_ready;
  logic        adj_sub = 1'b0;
  logic [7:0]  adj_sec_bcd = '0;
  logic [15:0] time_bcd;
  logic        tick;
  logic        warn;
  logic        time_out;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  game_timer_ext #(
    .CLK_FREQ  (100),
    .SIM_DIV   (1),
    .LEVELS    (10),
    .LVL_W     (4),
    .START_BCD (16'h0500),
    .WARN_SEC  (30)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .enable      (enable),
    .load        (load),
    .load_bcd    (load_bcd),
    .mode_up     (mode_up),
    .stability   (stability),
    .adj_valid   (adj_valid),
    .adj_ready   (adj_ready),
    .adj_sub     (adj_sub),
    .adj_sec_bcd (adj_sec_bcd),
    .time_bcd    (time_bcd),
    .tick        (tick),
    .warn        (warn),
    .time_out    (time_out)
  );

  typedef struct {
    logic [15:0] bcd;
    logic        up;
    logic        exp_warn;
    logic        exp_to;
  } vec_t;

  vec_t vecs [8];

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [15:0] v);
    load = 1'b1;
    load_bcd = v;
    cyc();
    load = 1'b0;
  endtask

  task automatic run_to_tick(input int lim, output int n);
    n = 0;
    do begin
      cyc();
      n++;
    end while (!tick && n < lim);
  endtask

  // ---------------- reference model (seconds domain) ---------------
  int m_sec, m_cnt, m_amt;
  bit m_busy, m_pend, m_sub, m_tick, m_to;
  bit m_blink = 1'b1;

  function automatic int b2s(logic [15:0] b);
    return b[15:12] * 600 + b[11:8] * 60 + b[7:4] * 10 + b[3:0];
  endfunction

  function automatic logic [15:0] s2b(int s);
    return {4'(s / 600), 4'((s / 60) % 10),
            4'((s % 60) / 10), 4'(s % 10)};
  endfunction

  function automatic logic [7:0] b8(int v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

  function automatic bit m_cond();
    return !mode_up && m_sec <= 30 && !m_to;
  endfunction

  task automatic model_step();
    int per, s, lim, hi, lo;
    bit due, at_end;
    if (rst || !m_cond()) m_blink = 1'b1;
    else if (m_tick) m_blink = !m_blink;
    lim = mode_up ? 5999 : 0;
    if (rst) begin
      m_sec = 300; m_cnt = 0; m_busy = 0;
      m_pend = 0; m_tick = 0; m_to = 0;
    end else if (load) begin
      m_sec = b2s(load_bcd); m_cnt = 0; m_busy = 0;
      m_pend = 0; m_tick = 0; m_to = 0;
    end else if (m_busy) begin
      m_busy = 0;
      m_tick = 0;
      if (m_sub) m_sec = (m_sec > m_amt) ? m_sec - m_amt : 0;
      else m_sec = (m_sec + m_amt > 5999) ? 5999 : m_sec + m_amt;
      if (m_sec == lim) begin
        m_to = 1; m_pend = 0;
      end else m_to = 0;
    end else begin
      s = (stability > 9) ? 9 : int'(stability);
      per = 100 - ((9 - s) * 100) / 18;
      due = enable && (m_cnt >= per - 1);
      at_end = (m_sec == lim);
      m_tick = 0;
      if (adj_valid) begin
        hi = adj_sec_bcd[7:4];
        lo = adj_sec_bcd[3:0];
        m_busy = 1;
        m_sub = adj_sub;
        m_amt = (lo <= 9 && hi * 10 + lo <= 59) ? hi * 10 + lo : 0;
        if (!m_to && !at_end && (m_pend || due)) m_pend = 1;
      end else if (m_to) begin
        m_tick = 0;
      end else if (at_end) begin
        m_to = 1; m_pend = 0;
      end else if (m_pend || due) begin
        m_sec += mode_up ? 1 : -1;
        m_cnt = 0; m_pend = 0; m_tick = 1;
        if (m_sec == lim) m_to = 1;
      end else if (enable) begin
        m_cnt++;
      end
    end
  endtask

  function automatic logic [15:0] rnd_time();
    case ($urandom_range(0, 3))
      0: return {8'h00, b8($urandom_range(0, 4))};
      1: return {8'h99, b8($urandom_range(55, 59))};
      2: return {8'h00, b8($urandom_range(0, 59))};
      default: return {b8($urandom_range(0, 99)),
                       b8($urandom_range(0, 59))};
    endcase
  endfunction

  initial begin
    int n;
    int nt;
    bit exp_warn;

    vecs[0] = '{16'h0030, 1'b0, 1'b1, 1'b0};
    vecs[1] = '{16'h0031, 1'b0, 1'b0, 1'b0};
    vecs[2] = '{16'h0000, 1'b0, 1'b0, 1'b1};
    vecs[3] = '{16'h9959, 1'b1, 1'b0, 1'b1};
    vecs[4] = '{16'h9959, 1'b0, 1'b0, 1'b0};
    vecs[5] = '{16'h0000, 1'b1, 1'b0, 1'b0};
    vecs[6] = '{16'h0029, 1'b0, 1'b1, 1'b0};
    vecs[7] = '{16'h1234, 1'b0, 1'b0, 1'b0};

    rst = 1'b1;
    cyc();
    rst = 1'b0;
    chk("rst_time", time_bcd, 16'h0500);
    chk("rst_tick", tick, 0);
    chk("rst_to", time_out, 0);
    chk("rst_ready", adj_ready, 1);
    chk("rst_warn", warn, 0);

    foreach (vecs[i]) begin
      enable = 1'b0;
      mode_up = vecs[i].up;
      do_load(vecs[i].bcd);
      chk("vec_load", time_bcd, vecs[i].bcd);
      cyc();
      chk("vec_time", time_bcd, vecs[i].bcd);
      chk("vec_to", time_out, vecs[i].exp_to);
      chk("vec_warn", warn, vecs[i].exp_warn);
    end

    // countdown 00:03 at slowest level
    mode_up = 1'b0;
    stability = 4'd9;
    enable = 1'b0;
    do_load(16'h0003);
    enable = 1'b1;
    run_to_tick(150, n);
    chk("cd_per1", n, 100);
    chk("cd_t1", time_bcd, 16'h0002);
    run_to_tick(150, n);
    chk("cd_per2", n, 100);
    chk("cd_t2", time_bcd, 16'h0001);
    run_to_tick(150, n);
    chk("cd_per3", n, 100);
    chk("cd_t3", time_bcd, 16'h0000);
    chk("cd_to", time_out, 1);
    nt = 0;
    repeat (250) begin
      cyc();
      if (tick) nt++;
    end
    chk("cd_noticks", nt, 0);

    // speed levels and mid-count level change
    stability = 4'd0;
    do_load(16'h0500);
    run_to_tick(150, n);
    chk("lvl0_per", n, 50);
    stability = 4'd3;
    run_to_tick(150, n);
    chk("lvl3_per", n, 67);
    stability = 4'd9;
    nt = 0;
    repeat (70) begin
      cyc();
      if (tick) nt++;
    end
    chk("lvl9_quiet", nt, 0);
    stability = 4'd0;
    cyc();
    chk("lvl_switch_tick", tick, 1);

    // bonus and penalty
    enable = 1'b0;
    do_load(16'h0010);
    adj_valid = 1'b1;
    adj_sub = 1'b0;
    adj_sec_bcd = 8'h55;
    cyc();
    adj_valid = 1'b0;
    chk("add_ready0", adj_ready, 0);
    chk("add_hold", time_bcd, 16'h0010);
    cyc();
    chk("add_res", time_bcd, 16'h0105);
    chk("add_ready1", adj_ready, 1);
    do_load(16'h0020);
    adj_valid = 1'b1;
    adj_sub = 1'b1;
    adj_sec_bcd = 8'h45;
    cyc();
    adj_valid = 1'b0;
    cyc();
    chk("sub_res", time_bcd, 16'h0000);
    chk("sub_to", time_out, 1);

    // up mode to 99:59, saturating add
    mode_up = 1'b1;
    stability = 4'd9;
    do_load(16'h9958);
    enable = 1'b1;
    run_to_tick(150, n);
    chk("up_per", n, 100);
    chk("up_time", time_bcd, 16'h9959);
    chk("up_to", time_out, 1);
    enable = 1'b0;
    do_load(16'h9950);
    adj_valid = 1'b1;
    adj_sub = 1'b0;
    adj_sec_bcd = 8'h30;
    cyc();
    adj_valid = 1'b0;
    cyc();
    chk("sat_time", time_bcd, 16'h9959);
    chk("sat_to", time_out, 1);

    // adjustment colliding with a due step
    mode_up = 1'b0;
    do_load(16'h0100);
    enable = 1'b1;
    repeat (99) cyc();
    adj_valid = 1'b1;
    adj_sub = 1'b0;
    adj_sec_bcd = 8'h05;
    cyc();
    adj_valid = 1'b0;
    chk("col_hold", time_bcd, 16'h0100);
    chk("col_tick0", tick, 0);
    cyc();
    chk("col_adj", time_bcd, 16'h0105);
    chk("col_tick1", tick, 0);
    cyc();
    chk("col_step", time_bcd, 16'h0104);
    chk("col_tick2", tick, 1);

    // priorities
    enable = 1'b0;
    rst = 1'b1;
    load = 1'b1;
    load_bcd = 16'h1111;
    adj_valid = 1'b1;
    adj_sec_bcd = 8'h10;
    cyc();
    rst = 1'b0;
    chk("pri_rst", time_bcd, 16'h0500);
    chk("pri_rst_rdy", adj_ready, 1);
    cyc();
    load = 1'b0;
    chk("pri_load", time_bcd, 16'h1111);
    chk("pri_load_rdy", adj_ready, 1);
    chk("pri_load_to", time_out, 0);
    cyc();
    chk("pri_acc", adj_ready, 0);
    adj_valid = 1'b0;
    do_load(16'h0200);
    chk("pri_midadj", time_bcd, 16'h0200);
    chk("pri_midadj_rdy", adj_ready, 1);
    cyc();
    chk("pri_noadj", time_bcd, 16'h0200);

    // random traffic against the model
    rst = 1'b1;
    @(posedge clk);
    model_step();
    #1;
    rst = 1'b0;
    enable = 1'b1;
    for (int c = 0; c < 5000; c++) begin
      rst = ($urandom_range(0, 799) == 0);
      load = ($urandom_range(0, 149) == 0);
      if (load) load_bcd = rnd_time();
      adj_valid = ($urandom_range(0, 24) == 0);
      adj_sub = 1'($urandom_range(0, 1));
      adj_sec_bcd = ($urandom_range(0, 7) == 0)
                  ? 8'($urandom_range(0, 255))
                  : b8($urandom_range(0, 59));
      if ($urandom_range(0, 299) == 0) mode_up = !mode_up;
      if ($urandom_range(0, 99) == 0)
        stability = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 49) == 0)
        enable = ($urandom_range(0, 99) < 85);
      @(posedge clk);
      model_step();
      #1;
`ifdef TIMER_WARN_BLINK_EN
      exp_warn = m_cond() && m_blink;
`else
      exp_warn = m_cond();
`endif
      chk("rnd_time", time_bcd, s2b(m_sec));
      chk("rnd_tick", tick, m_tick);
      chk("rnd_to", time_out, m_to);
      chk("rnd_ready", adj_ready, !m_busy);
      chk("rnd_warn", warn, exp_warn);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
